// File: rtl/mem_refill_ctrl.sv
// Memory-side refill/write-back stage behind the cache controller.
// Returns 16-byte lines critical-word-first after a fixed latency and absorbs dirty-victim write-backs.
module mem_refill_ctrl #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADR_WIDTH     = 32,
  parameter int DATAMEM_WIDTH = 128,
  parameter int WORD_NUM      = 4,
  parameter int MEM_DEPTH     = 1024,
  parameter int LATENCY       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_cc2mem,
  input  logic [ADR_WIDTH-1:0]     i_adr_cc2mem,
  input  logic                     i_wb_req_cc2mem,
  input  logic [ADR_WIDTH-1:0]     i_wb_adr_cc2mem,
  input  logic [DATAMEM_WIDTH-1:0] i_wb_dat_cc2mem,
  output logic                     o_ack_mem2cc,
  output logic [WORD_WIDTH-1:0]    o_dat_mem2cc,
  output logic                     o_busy_mem2cc,
  output logic                     o_ovf_mem2cc
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int LINE_W = IDX_W - 2;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WB, WAIT, BURST} state_t;

  state_t                     r_state;
  logic [WORD_WIDTH-1:0]      r_mem [MEM_DEPTH];
  logic [3:0]                 r_latCnt;
  logic [2:0]                 r_beat;
  logic [1:0]                 r_wordCnt;
  logic [LINE_W-1:0]          r_line;
  logic [LINE_W-1:0]          r_wbLine;
  logic [1:0]                 r_wbCnt;
  logic [DATAMEM_WIDTH-1:0]   r_wbData;
  logic                       r_pendValid;
  logic [IDX_W-1:0]           r_pendIdx;
  logic                       r_ack;
  logic [WORD_WIDTH-1:0]      r_dat;
  logic                       r_ovf;
  logic [IDX_W-1:0]           w_startIdx;
  logic                       w_unused;

  // A fresh request takes precedence over the pending slot when both are present in IDLE.
  assign w_startIdx = i_req_cc2mem ? i_adr_cc2mem[IDX_W+1:2] : r_pendIdx;
  assign w_unused   = ^{i_adr_cc2mem[ADR_WIDTH-1:IDX_W+2], i_adr_cc2mem[1:0],
                        i_wb_adr_cc2mem[ADR_WIDTH-1:IDX_W+2], i_wb_adr_cc2mem[3:0]};

  assign o_ack_mem2cc  = r_ack;
  assign o_dat_mem2cc  = r_dat;
  assign o_busy_mem2cc = (r_state != IDLE) || r_pendValid;
  assign o_ovf_mem2cc  = r_ovf;

  // Backing store is not reset; a reset in the middle of a write-back stops further writes.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == WB) begin
      r_mem[{r_wbLine, r_wbCnt}] <= r_wbData[int'(r_wbCnt)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_latCnt    <= '0;
      r_beat      <= '0;
      r_wordCnt   <= '0;
      r_line      <= '0;
      r_wbLine    <= '0;
      r_wbCnt     <= '0;
      r_wbData    <= '0;
      r_pendValid <= 1'b0;
      r_pendIdx   <= '0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_wb_req_cc2mem) begin
            r_wbLine <= i_wb_adr_cc2mem[IDX_W+1:4];
            r_wbData <= i_wb_dat_cc2mem;
            r_wbCnt  <= '0;
            r_state  <= WB;
            if (i_req_cc2mem) begin
              if (r_pendValid) begin
                r_ovf <= 1'b1;
              end else begin
                r_pendValid <= 1'b1;
                r_pendIdx   <= i_adr_cc2mem[IDX_W+1:2];
              end
            end
          end else if (i_req_cc2mem || r_pendValid) begin
            r_line    <= w_startIdx[IDX_W-1:2];
            r_wordCnt <= w_startIdx[1:0];
            r_latCnt  <= LAT_INIT;
            r_beat    <= '0;
            r_state   <= (LATENCY == 1) ? BURST : WAIT;
            if (!i_req_cc2mem) r_pendValid <= 1'b0;
          end
        end
        WB: begin
          r_wbCnt <= r_wbCnt + 2'd1;
          if (r_wbCnt == 2'd3) r_state <= IDLE;
        end
        WAIT: begin
          r_latCnt <= r_latCnt - 4'd1;
          if (r_latCnt == 4'd1) r_state <= BURST;
        end
        BURST: begin
          // Four acks on beats 0..3; beat 4 only drops ack and returns to IDLE.
          if (r_beat == 3'd4) begin
            r_state <= IDLE;
          end else begin
            r_ack     <= 1'b1;
            r_dat     <= r_mem[{r_line, r_wordCnt}];
            r_wordCnt <= r_wordCnt + 2'd1;
            r_beat    <= r_beat + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (r_state != IDLE) begin
        if (i_req_cc2mem) begin
          if (r_pendValid) begin
            r_ovf <= 1'b1;
          end else begin
            r_pendValid <= 1'b1;
            r_pendIdx   <= i_adr_cc2mem[IDX_W+1:2];
          end
        end
        if (i_wb_req_cc2mem) r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench for mem_refill_ctrl: stimulus pushes expected refill words, monitors pop them on ack.
module tb_mem_refill_ctrl;

  localparam logic [31:0] A0 = 32'hA000_1110, A1 = 32'hA001_2221, A2 = 32'hA002_3332, A3 = 32'hA003_4443;
  localparam logic [31:0] D0 = 32'hD000_0D00, D1 = 32'hD111_1D11, D2 = 32'hD222_2D22, D3 = 32'hD333_3D33;

  typedef struct {
    logic [31:0] dat;
    int          edgeN;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, wbReq;
  logic [31:0]  adr, wbAdr;
  logic [127:0] wbDat;
  logic         ack, busy, ovf;
  logic [31:0]  dat;
  logic         bReq, bWbReq;
  logic [31:0]  bAdr, bWbAdr;
  logic [127:0] bWbDat;
  logic         bAck, bBusy, bOvf;
  logic [31:0]  bDat;

  int   edgeNo = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t expQ1[$];

  mem_refill_ctrl #(.LATENCY(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_cc2mem(req), .i_adr_cc2mem(adr),
    .i_wb_req_cc2mem(wbReq), .i_wb_adr_cc2mem(wbAdr), .i_wb_dat_cc2mem(wbDat),
    .o_ack_mem2cc(ack), .o_dat_mem2cc(dat), .o_busy_mem2cc(busy), .o_ovf_mem2cc(ovf)
  );

  mem_refill_ctrl #(.LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_cc2mem(bReq), .i_adr_cc2mem(bAdr),
    .i_wb_req_cc2mem(bWbReq), .i_wb_adr_cc2mem(bWbAdr), .i_wb_dat_cc2mem(bWbDat),
    .o_ack_mem2cc(bAck), .o_dat_mem2cc(bDat), .o_busy_mem2cc(bBusy), .o_ovf_mem2cc(bOvf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeNo <= edgeNo + 1;

  // Each ack must match the oldest expected word, both in data and in the edge it appears after.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL lat4_unexpected_ack: got data %h after edge %0d, required no ack", dat, edgeNo);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (dat !== e.dat || edgeNo != e.edgeN) begin
          errors++;
          $display("[TB] FAIL lat4_ack: got %h after edge %0d, required %h after edge %0d",
                   dat, edgeNo, e.dat, e.edgeN);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bAck === 1'b1) begin
      checks++;
      if (expQ1.size() == 0) begin
        errors++;
        $display("[TB] FAIL lat1_unexpected_ack: got data %h after edge %0d, required no ack", bDat, edgeNo);
      end else begin
        exp_t e;
        e = expQ1.pop_front();
        if (bDat !== e.dat || edgeNo != e.edgeN) begin
          errors++;
          $display("[TB] FAIL lat1_ack: got %h after edge %0d, required %h after edge %0d",
                   bDat, edgeNo, e.dat, e.edgeN);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic pushWord(input bit lat1, input int edgeN, input logic [31:0] w);
    exp_t e;
    e.dat   = w;
    e.edgeN = edgeN;
    if (lat1) expQ1.push_back(e);
    else      expQ.push_back(e);
  endtask

  task automatic pushBurst(input bit lat1, input int firstEdge,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    pushWord(lat1, firstEdge,     w0);
    pushWord(lat1, firstEdge + 1, w1);
    pushWord(lat1, firstEdge + 2, w2);
    pushWord(lat1, firstEdge + 3, w3);
  endtask

  // Drives one cycle of requests into the LATENCY=4 instance; returns the edge that samples them.
  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w,
                               input logic [31:0] wa, input logic [127:0] wd, output int sampleEdge);
    req        = r;
    adr        = a;
    wbReq      = w;
    wbAdr      = wa;
    wbDat      = wd;
    sampleEdge = edgeNo + 1;
    tick();
    req   = 1'b0;
    wbReq = 1'b0;
  endtask

  initial begin
    int e;
    rst = 1'b1;
    req = 1'b0; adr = '0; wbReq = 1'b0; wbAdr = '0; wbDat = '0;
    bReq = 1'b0; bAdr = '0; bWbReq = 1'b0; bWbAdr = '0; bWbDat = '0;
    repeat (3) tick();
    checkOutput("reset_ack", {31'b0, ack}, 32'd0);
    checkOutput("reset_dat", dat, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // Preload words 0x40..0x43 in both instances through a write-back of line 0x100.
    bWbReq = 1'b1; bWbAdr = 32'h100; bWbDat = {A3, A2, A1, A0};
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, {A3, A2, A1, A0}, e);
    bWbReq = 1'b0;
    checkOutput("wb_busy", {31'b0, busy}, 32'd1);
    repeat (5) tick();

    // LATENCY=1: first ack directly after the edge following the sample edge.
    bReq = 1'b1; bAdr = 32'h100;
    e = edgeNo + 1;
    pushBurst(1'b1, e + 1, A0, A1, A2, A3);
    tick();
    bReq = 1'b0;
    repeat (6) tick();

    // Critical word 2 with LATENCY=4 and busy window.
    applyStimulus(1'b1, 32'h108, 1'b0, 32'h0, 128'h0, e);
    pushBurst(1'b0, e + 4, A2, A3, A0, A1);
    checkOutput("t1_busy_start", {31'b0, busy}, 32'd1);
    repeat (7) tick();
    checkOutput("t1_busy_last_ack", {31'b0, busy}, 32'd1);
    tick();
    checkOutput("t1_busy_end", {31'b0, busy}, 32'd0);
    checkOutput("t1_ack_end", {31'b0, ack}, 32'd0);

    // Write-back and refill in the same cycle: refill waits in the pending slot.
    applyStimulus(1'b1, 32'h204, 1'b1, 32'h200, {D3, D2, D1, D0}, e);
    pushBurst(1'b0, e + 9, D1, D2, D3, D0);
    checkOutput("t3_busy", {31'b0, busy}, 32'd1);
    repeat (13) tick();
    checkOutput("t3_busy_end", {31'b0, busy}, 32'd0);

    // Two requests during one burst: first pending, second dropped.
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 128'h0, e);
    pushBurst(1'b0, e + 4, A0, A1, A2, A3);
    repeat (4) tick();
    applyStimulus(1'b1, 32'h10C, 1'b0, 32'h0, 128'h0, e);
    checkOutput("t4_ovf_before_drop", {31'b0, ovf}, 32'd0);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 128'h0, e);
    checkOutput("t4_ovf_after_drop", {31'b0, ovf}, 32'd1);
    pushBurst(1'b0, e + 7, A3, A0, A1, A2);
    repeat (11) tick();
    checkOutput("t4_busy_end", {31'b0, busy}, 32'd0);
    checkOutput("t4_ovf_sticky", {31'b0, ovf}, 32'd1);

    // Upper address bits alias onto the same words.
    applyStimulus(1'b1, 32'h1000_0104, 1'b0, 32'h0, 128'h0, e);
    pushBurst(1'b0, e + 4, A1, A2, A3, A0);
    repeat (8) tick();
    checkOutput("alias_ovf_sticky", {31'b0, ovf}, 32'd1);

    // Reset during the second ack of a burst.
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 128'h0, e);
    pushWord(1'b0, e + 4, A0);
    pushWord(1'b0, e + 5, A1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_ack", {31'b0, ack}, 32'd0);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    applyStimulus(1'b1, 32'h10C, 1'b0, 32'h0, 128'h0, e);
    pushBurst(1'b0, e + 4, A3, A0, A1, A2);
    repeat (9) tick();
    checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);

    checkOutput("lat4_queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("lat1_queue_drained", 32'(expQ1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
